// File: rtl/switch_debouncer_pkg.sv
// ============================================================================
// Module  : switch_debouncer_pkg
// Purpose : Shared defaults, per-bit debounce state type and counter sizing.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_debouncer_pkg;

   localparam int SW_WIDTH           = 10;
   localparam int SW_SYNC_STAGES     = 2;
   localparam int SW_DEBOUNCE_CYCLES = 500000;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_e;

   function automatic int sw_cnt_width(input int cycles);
      return $clog2(cycles);
   endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debounce_bit.sv
// ============================================================================
// Module  : switch_debounce_bit
// Purpose : One switch bit: synchroniser, stability counter and clean level.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES     = SW_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic changed
);

   localparam int                CNT_W    = sw_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   changed_q, changed_d;
   logic                   s;
   db_state_e              state;

   assign s     = sync_q[SYNC_STAGES-1];
   assign state = (cnt_q == '0) ? DB_STABLE : DB_PENDING;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], raw};
      cnt_d     = cnt_q;
      level_d   = level_q;
      changed_d = 1'b0;
      unique case (state)
         DB_STABLE: begin
            if (s != level_q) cnt_d = CNT_ONE;
         end
         DB_PENDING: begin
            // Any agreement while pending aborts the run; the next
            // disagreement starts counting from scratch.
            if (s == level_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               level_d   = s;
               changed_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         changed_q <= changed_d;
      end
   end

   assign level   = level_q;
   assign changed = changed_q;

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// Module  : switch_debouncer
// Purpose : WIDTH-bit switch debouncer feeding the PIO in_port. Optional
//           sticky edge flags under SWITCH_DEBOUNCER_EDGE_LATCH_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int SYNC_STAGES     = SW_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_changed
`ifdef SWITCH_DEBOUNCER_EDGE_LATCH_EN
   ,
   output logic [WIDTH-1:0] edge_flag,
   input  logic [WIDTH-1:0] edge_clear
`endif
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (sw_raw[i]),
         .level   (sw_out[i]),
         .changed (sw_changed[i])
      );
   end

`ifdef SWITCH_DEBOUNCER_EDGE_LATCH_EN
   logic [WIDTH-1:0] edge_flag_q, edge_flag_d;

   // Set dominates clear so a pulse coinciding with a clear is not lost.
   always_comb begin
      edge_flag_d = (edge_flag_q & ~edge_clear) | sw_changed;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edge_flag_q <= '0;
      else          edge_flag_q <= edge_flag_d;
   end

   assign edge_flag = edge_flag_q;
`else
   // Level and pulse outputs only.
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// Module  : tb_switch_debouncer
// Purpose : Self-checking bench for switch_debouncer (WIDTH=10, SYNC=2, DB=8).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

   localparam int W  = 10;
   localparam int SS = 2;
   localparam int DC = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_out;
   logic [W-1:0] sw_changed;
   logic [W-1:0] edge_clear;
`ifdef SWITCH_DEBOUNCER_EDGE_LATCH_EN
   logic [W-1:0] edge_flag;
`endif

   int n_checks = 0;
   int n_errors = 0;

   switch_debouncer #(
      .WIDTH           (W),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw),
      .sw_out     (sw_out),
      .sw_changed (sw_changed)
`ifdef SWITCH_DEBOUNCER_EDGE_LATCH_EN
      ,
      .edge_flag  (edge_flag),
      .edge_clear (edge_clear)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: raw samples delayed through a pipe, then a level flips
   // once the last DC delayed samples all disagree with it.
   logic [W-1:0] pipe [SS];
   logic [W-1:0] hist [$];
   logic [W-1:0] m_out, m_chg, m_flag;

   typedef struct {
      logic [W-1:0] raw;
      int           cycles;
      logic [W-1:0] exp_out;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < SS; j++) pipe[j] = '0;
      hist.delete();
      for (int j = 0; j < DC; j++) hist.push_back('0);
      m_out  = '0;
      m_chg  = '0;
      m_flag = '0;
   endtask

   task automatic tick();
      logic [W-1:0] s_cur;
      bit           all_diff;
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else begin
         m_flag = (m_flag & ~edge_clear) | m_chg;
         s_cur  = pipe[SS-1];
         hist.push_back(s_cur);
         if (hist.size() > DC) void'(hist.pop_front());
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (hist[k]) if (hist[k][b] == m_out[b]) all_diff = 1'b0;
            m_chg[b] = all_diff;
            if (all_diff) m_out[b] = s_cur[b];
         end
         for (int j = SS - 1; j > 0; j--) pipe[j] = pipe[j-1];
         pipe[0] = sw_raw;
      end
      #1;
      check("out", sw_out, m_out);
      check("chg", sw_changed, m_chg);
`ifdef SWITCH_DEBOUNCER_EDGE_LATCH_EN
      check("flag", edge_flag, m_flag);
`endif
   endtask

   task automatic wait_change(input string name, input logic [W-1:0] exp_pulse);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 20) begin
         tick();
         n++;
         if (sw_changed != '0) seen = 1'b1;
      end
      check({name, "_pulse"}, sw_changed, exp_pulse);
      check_int({name, "_latency"}, n, SS + DC);
   endtask

   task automatic do_reset(input int cycles);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_async_out", sw_out, '0);
      check("rst_async_chg", sw_changed, '0);
      for (int c = 0; c < cycles; c++) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [8];
      int   glitch_hits;
      int   hold;

      vecs[0] = '{raw: 10'h000, cycles: 50, exp_out: 10'h000};
      vecs[1] = '{raw: 10'h001, cycles: 12, exp_out: 10'h001};
      vecs[2] = '{raw: 10'h3FF, cycles: 12, exp_out: 10'h3FF};
      vecs[3] = '{raw: 10'h000, cycles: 12, exp_out: 10'h000};
      vecs[4] = '{raw: 10'h2AA, cycles: 12, exp_out: 10'h2AA};
      vecs[5] = '{raw: 10'h155, cycles: 12, exp_out: 10'h155};
      vecs[6] = '{raw: 10'h000, cycles: 5,  exp_out: 10'h155};
      vecs[7] = '{raw: 10'h155, cycles: 12, exp_out: 10'h155};

      reset_n    = 1'b0;
      sw_raw     = '0;
      edge_clear = '0;
      model_reset();
      for (int c = 0; c < 3; c++) tick();
      check("reset_out", sw_out, '0);
      check("reset_chg", sw_changed, '0);
      reset_n = 1'b1;

      foreach (vecs[v]) begin
         sw_raw = vecs[v].raw;
         for (int c = 0; c < vecs[v].cycles; c++) tick();
         check("tbl_out", sw_out, vecs[v].exp_out);
      end

      // Single bit rise, then all bits together in both directions.
      do_reset(2);
      sw_raw = 10'h001;
      wait_change("bit0_rise", 10'h001);
      check("bit0_out", sw_out, 10'h001);
      tick();
      check("bit0_pulse_gone", sw_changed, '0);
      sw_raw = 10'h000;
      wait_change("bit0_fall", 10'h001);
      for (int c = 0; c < 3; c++) tick();
      sw_raw = 10'h3FF;
      wait_change("all_rise", 10'h3FF);
      check("all_out_hi", sw_out, 10'h3FF);
      tick();
      sw_raw = 10'h000;
      wait_change("all_fall", 10'h3FF);
      check("all_out_lo", sw_out, 10'h000);

      // Glitches on bit 3: one 5-cycle pulse then 7-cycle bursts.
      glitch_hits = 0;
      sw_raw = 10'h008;
      for (int c = 0; c < 5; c++) begin tick(); glitch_hits += int'(sw_out[3] | sw_changed[3]); end
      for (int r = 0; r < 4; r++) begin
         sw_raw = 10'h000;
         tick(); glitch_hits += int'(sw_out[3] | sw_changed[3]);
         sw_raw = 10'h008;
         for (int c = 0; c < 7; c++) begin tick(); glitch_hits += int'(sw_out[3] | sw_changed[3]); end
      end
      sw_raw = 10'h000;
      for (int c = 0; c < 12; c++) begin tick(); glitch_hits += int'(sw_out[3] | sw_changed[3]); end
      check_int("glitch_hits", glitch_hits, 0);

      // Reset while bit 0 is pending at count 6, then a fresh full debounce.
      sw_raw = 10'h001;
      for (int c = 0; c < 8; c++) tick();
      do_reset(3);
      wait_change("rst_fresh", 10'h001);

      // Random stimulus against the model.
      for (int r = 0; r < 250; r++) begin
         sw_raw     = W'($urandom);
         edge_clear = W'($urandom) & W'($urandom);
         hold       = int'($urandom_range(1, 14));
         for (int c = 0; c < hold; c++) tick();
      end
      edge_clear = '0;

`ifdef SWITCH_DEBOUNCER_EDGE_LATCH_EN
      sw_raw = '0;
      do_reset(2);
      sw_raw = 10'h020;
      wait_change("e_set", 10'h020);
      tick();
      check("e_flag_set", edge_flag, 10'h020);
      for (int c = 0; c < 3; c++) tick();
      check("e_flag_hold", edge_flag, 10'h020);
      sw_raw = 10'h000;
      wait_change("e_fall", 10'h020);
      edge_clear = 10'h020;
      tick();
      check("e_set_wins", edge_flag, 10'h020);
      edge_clear = '0;
      tick();
      check("e_flag_kept", edge_flag, 10'h020);
      edge_clear = 10'h020;
      tick();
      edge_clear = '0;
      check("e_flag_clear", edge_flag, 10'h000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
